// File: rtl/abs_filter_pkg.sv
// Shared types for the absolute-difference filter chain: VIP packet type codes and
// the mask-stage packet-tracking state.
package abs_filter_pkg;

    localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VIDEO = 2'd1,
        OTHER = 2'd2
    } state_e;

endpackage

// File: rtl/abs_diff_pixel_cmp.sv
// Combinational per-symbol threshold: each symbol becomes all-ones when it reaches the
// threshold, and the pixel is flagged changed when any symbol does.
module abs_diff_pixel_cmp #(
    parameter int unsigned BPS = 8,
    parameter int unsigned SPB = 3
) (
    input  logic [BPS*SPB-1:0] pixel_i,
    input  logic [BPS-1:0]     thr_i,
    output logic [BPS*SPB-1:0] mask_o,
    output logic               changed_o
);

    always_comb begin
        mask_o    = '0;
        changed_o = 1'b0;
        for (int unsigned s = 0; s < SPB; s++) begin
            if (pixel_i[s*BPS +: BPS] >= thr_i) begin
                mask_o[s*BPS +: BPS] = '1;
                changed_o            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/abs_diff_mask_stats.sv
// VIP stream stage: thresholds abs-difference video payload into a binary change mask,
// passes other packets through, and counts changed pixels per frame when
// ABS_DIFF_MASK_STATS_EN is defined (otherwise the count outputs are tied to zero).
module abs_diff_mask_stats
    import abs_filter_pkg::*;
#(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3,
    parameter int unsigned COUNT_W          = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic                                   asi_din_ready,
    input  logic                                   asi_din_valid,
    input  logic                                   asi_din_startofpacket,
    input  logic                                   asi_din_endofpacket,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] asi_din_data,
    input  logic                                   aso_dout_ready,
    output logic                                   aso_dout_valid,
    output logic                                   aso_dout_startofpacket,
    output logic                                   aso_dout_endofpacket,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] aso_dout_data,
    input  logic [BITS_PER_SYMBOL-1:0]             threshold,
    output logic [COUNT_W-1:0]                     changed_count,
    output logic                                   count_valid
);

    localparam int unsigned DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    state_e                     state_q, state_d;
    logic                       valid_q, valid_d;
    logic                       sop_q, sop_d;
    logic                       eop_q, eop_d;
    logic [DW-1:0]              data_q, data_d;
    logic [BITS_PER_SYMBOL-1:0] thr_q, thr_d;
    logic [DW-1:0]              mask_pix;
    logic                       pix_changed;
    logic                       accept;
    logic                       frame_start;
    logic                       frame_end;
    logic                       pix_count;

    abs_diff_pixel_cmp #(
        .BPS (BITS_PER_SYMBOL),
        .SPB (SYMBOLS_PER_BEAT)
    ) u_cmp (
        .pixel_i   (asi_din_data),
        .thr_i     (thr_q),
        .mask_o    (mask_pix),
        .changed_o (pix_changed)
    );

    assign asi_din_ready = aso_dout_ready | ~valid_q;
    assign accept        = asi_din_valid & asi_din_ready;

    // Next-state: output register load/drain and packet decode on accepted beats
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q & ~aso_dout_ready;
        sop_d       = sop_q;
        eop_d       = eop_q;
        data_d      = data_q;
        thr_d       = thr_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_count   = 1'b0;
        if (accept) begin
            valid_d = 1'b1;
            sop_d   = asi_din_startofpacket;
            eop_d   = asi_din_endofpacket;
            data_d  = asi_din_data;
            if (asi_din_startofpacket) begin
                // A SOP always re-decodes, abandoning any unterminated frame
                if (asi_din_data[3:0] == VIP_PKT_VIDEO) begin
                    thr_d       = threshold;
                    frame_start = 1'b1;
                    frame_end   = asi_din_endofpacket;
                    state_d     = asi_din_endofpacket ? IDLE : VIDEO;
                end else begin
                    state_d = asi_din_endofpacket ? IDLE : OTHER;
                end
            end else begin
                case (state_q)
                    VIDEO: begin
                        data_d    = mask_pix;
                        pix_count = pix_changed;
                        if (asi_din_endofpacket) begin
                            frame_end = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    OTHER: begin
                        if (asi_din_endofpacket) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
            thr_q   <= thr_d;
        end
    end

    assign aso_dout_valid         = valid_q;
    assign aso_dout_startofpacket = sop_q;
    assign aso_dout_endofpacket   = eop_q;
    assign aso_dout_data          = data_q;

`ifdef ABS_DIFF_MASK_STATS_EN
    logic [COUNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               count_valid_q, count_valid_d;

    // Saturating per-frame counter; the published value includes the EOP beat
    always_comb begin
        run_cnt_d     = run_cnt_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        if (frame_start) begin
            run_cnt_d = '0;
        end else if (pix_count && (run_cnt_q != '1)) begin
            run_cnt_d = run_cnt_q + COUNT_W'(1);
        end
        if (frame_end) begin
            count_d       = run_cnt_d;
            count_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q     <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign changed_count = count_q;
    assign count_valid   = count_valid_q;
`else
    logic unused_stats;
    assign unused_stats  = frame_start ^ frame_end ^ pix_count;
    assign changed_count = '0;
    assign count_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_abs_diff_mask_stats.sv
// Self-checking bench for abs_diff_mask_stats: directed packet sequences plus a random
// frame under random backpressure, checked against a packet-level reference model.
module tb_abs_diff_mask_stats;

    localparam int unsigned DW = 24;
`ifdef ABS_DIFF_MASK_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic [7:0]    thr = 8'd0;
    logic          dout_ready = 1'b1;

    logic          din_ready, dout_valid, dout_sop, dout_eop, cv;
    logic [DW-1:0] dout_data;
    logic [31:0]   cnt;
    logic          s_din_ready, s_dout_valid, s_dout_sop, s_dout_eop, s_cv;
    logic [DW-1:0] s_dout_data;
    logic [3:0]    s_cnt;

    always #5 clk = ~clk;

    abs_diff_mask_stats dut (
        .clk(clk), .reset(reset),
        .asi_din_ready(din_ready), .asi_din_valid(din_valid),
        .asi_din_startofpacket(din_sop), .asi_din_endofpacket(din_eop), .asi_din_data(din_data),
        .aso_dout_ready(dout_ready), .aso_dout_valid(dout_valid),
        .aso_dout_startofpacket(dout_sop), .aso_dout_endofpacket(dout_eop), .aso_dout_data(dout_data),
        .threshold(thr), .changed_count(cnt), .count_valid(cv)
    );

    // Narrow-counter instance fed the same stream to exercise saturation
    abs_diff_mask_stats #(.COUNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .asi_din_ready(s_din_ready), .asi_din_valid(din_valid),
        .asi_din_startofpacket(din_sop), .asi_din_endofpacket(din_eop), .asi_din_data(din_data),
        .aso_dout_ready(dout_ready), .aso_dout_valid(s_dout_valid),
        .aso_dout_startofpacket(s_dout_sop), .aso_dout_endofpacket(s_dout_eop), .aso_dout_data(s_dout_data),
        .threshold(thr), .changed_count(s_cnt), .count_valid(s_cv)
    );

    int          n_assert = 0, n_fail = 0;
    int          rdy_pct = 100;
    bit          gaps = 1'b0;
    logic [DW+1:0] exp_q[$];
    bit          in_acc, out_acc;
    logic [DW+1:0] out_beat;
    bit          m_in_pkt, m_video, m_exp_cv;
    logic [7:0]  m_thr;
    int unsigned m_cnt, m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask_of(input logic [DW-1:0] px, input logic [7:0] t);
        logic [DW-1:0] m = '0;
        for (int s = 0; s < 3; s++) begin
            if (8'((px >> (8 * s)) & 24'hFF) >= t) m = m | (24'hFF << (8 * s));
        end
        return m;
    endfunction

    // Reference: track the packet currently open on the input side
    task automatic model_beat(input bit sop, input bit eop, input logic [DW-1:0] d);
        logic [DW-1:0] o = d;
        bit pulse = 1'b0;
        if (sop) begin
            m_video  = (d[3:0] == 4'h0);
            m_thr    = thr;
            m_cnt    = 0;
            m_in_pkt = !eop;
            pulse    = eop && m_video;
        end else if (m_in_pkt) begin
            if (m_video) begin
                o = mask_of(d, m_thr);
                if (o != '0) m_cnt++;
            end
            if (eop) begin
                pulse    = m_video;
                m_in_pkt = 1'b0;
            end
        end
        exp_q.push_back({sop, eop, o});
        m_exp_cv = pulse;
        if (pulse) m_last = m_cnt;
    endtask

    task automatic tick();
        logic [DW+1:0] e;
        @(negedge clk);
        in_acc   = din_valid && din_ready;
        out_acc  = dout_valid && dout_ready;
        out_beat = {dout_sop, dout_eop, dout_data};
        @(posedge clk);
        #1;
        m_exp_cv = 1'b0;
        if (out_acc) begin
            chk("out_beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_beat", 32'(out_beat), 32'(e));
            end
        end
        if (in_acc) model_beat(din_sop, din_eop, din_data);
        chk("count_valid", 32'(cv), STATS_EN ? 32'(m_exp_cv) : 32'd0);
        chk("changed_count", cnt, STATS_EN ? m_last : 32'd0);
        chk("sat_count_valid", 32'(s_cv), STATS_EN ? 32'(m_exp_cv) : 32'd0);
        chk("sat_changed_count", 32'(s_cnt), STATS_EN ? ((m_last > 15) ? 32'd15 : m_last) : 32'd0);
        dout_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic send(input bit sop, input bit eop, input logic [DW-1:0] d);
        int w = 0;
        if (gaps && ($urandom_range(3) == 0)) begin
            din_valid = 1'b0;
            tick();
        end
        din_valid = 1'b1; din_sop = sop; din_eop = eop; din_data = d;
        do begin
            tick();
            w++;
        end while (!in_acc && w < 200);
        chk("din_accept", 32'(in_acc), 32'd1);
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        din_valid = 1'b0;
        rdy_pct   = 100;
        while (exp_q.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        dout_ready = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_in_pkt = 1'b0; m_cnt = 0; m_last = 0; m_exp_cv = 1'b0;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_data", 32'(dout_data), 32'd0);
        chk("rst_changed_count", cnt, 32'd0);
        chk("rst_count_valid", 32'(cv), 32'd0);
        dout_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset mid-packet, then a fresh video frame
        thr = 8'd100;
        send(1'b1, 1'b0, 24'h000000);
        send(1'b0, 1'b0, 24'hC80000);
        send(1'b0, 1'b0, 24'h000001);
        do_reset();
        thr = 8'd50;
        send(1'b1, 1'b0, 24'hABC000);
        send(1'b0, 1'b0, 24'h003200);
        send(1'b0, 1'b1, 24'h313131);
        drain();
        chk("post_reset_count", cnt, STATS_EN ? 32'd1 : 32'd0);

        // Directed thresholding example
        thr = 8'd16;
        send(1'b1, 1'b0, 24'h000000);
        send(1'b0, 1'b0, 24'h080808);
        send(1'b0, 1'b0, 24'h100000);
        send(1'b0, 1'b1, 24'hFFFFFF);
        drain();
        chk("t2_count", cnt, STATS_EN ? 32'd2 : 32'd0);

        // Control packet passthrough, then stray beats outside any packet
        send(1'b1, 1'b0, 24'h00000F);
        for (int i = 0; i < 9; i++) send(1'b0, i == 8, 24'($urandom));
        send(1'b0, 1'b0, 24'h123456);
        send(1'b0, 1'b1, 24'h000000);
        drain();
        chk("ctrl_count_kept", cnt, STATS_EN ? 32'd2 : 32'd0);

        // Empty video packet publishes zero
        send(1'b1, 1'b1, 24'h000000);
        drain();
        chk("empty_video_count", cnt, 32'd0);

        // Random frame under 50% backpressure and input gaps (reduced size for runtime)
        rdy_pct = 50;
        gaps    = 1'b1;
        thr     = 8'($urandom_range(40, 220));
        send(1'b1, 1'b0, 24'($urandom) & 24'hFFFFF0);
        for (int i = 0; i < 48 * 32; i++) begin
            rdy_pct = 50;
            send(1'b0, i == 48 * 32 - 1, 24'($urandom));
        end
        drain();
        gaps = 1'b0;

        // Missing EOP: first frame abandoned, second counted
        thr = 8'd128;
        send(1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 24'hFFFFFF);
        send(1'b1, 1'b0, 24'h000010);
        send(1'b0, 1'b0, 24'h800000);
        send(1'b0, 1'b0, 24'h7F7F7F);
        send(1'b0, 1'b1, 24'h000080);
        drain();
        chk("resync_count", cnt, STATS_EN ? 32'd2 : 32'd0);

        // threshold=0: every pixel changed; 20 pixels saturate the 4-bit counter
        thr = 8'd0;
        send(1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < 20; i++) send(1'b0, i == 19, 24'($urandom) & 24'h0F0F0F);
        drain();
        chk("thr0_count", cnt, STATS_EN ? 32'd20 : 32'd0);
        chk("thr0_sat_count", 32'(s_cnt), STATS_EN ? 32'd15 : 32'd0);

        // threshold=max: only saturated symbols count
        thr = 8'hFF;
        send(1'b1, 1'b0, 24'h000000);
        send(1'b0, 1'b0, 24'hFEFEFE);
        send(1'b0, 1'b0, 24'h00FF00);
        for (int i = 0; i < 6; i++) send(1'b0, i == 5, 24'($urandom) | 24'h0000F0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
